// File: rtl/regfile_wr_arb_if.sv
// Write-request, clear-control and regfile write-port bundle for regfile_wr_arb.
// The master modport is the requester/control side, and the slave modport is the arbiter.
interface regfile_wr_arb_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          clr_start;
  logic          busy;
  logic          last_grant;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clr_start,
    input  req0_ready, req1_ready, busy, last_grant,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clr_start,
    output req0_ready, req1_ready, busy, last_grant,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Round-robin write-port arbiter with a full-clear sweep for a 32x32 register file.
// Optional macro RF_ZERO_GUARD_EN blocks requester writes to register 0.
//
// state | meaning
// ARB   | arbitrate requesters; a clr_start pulse starts a sweep
// CLEAR | write zero to one address per cycle, from 0 to DEPTH-1
module regfile_wr_arb #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 32
) (
  input logic              clk,
  input logic              rst,
  regfile_wr_arb_if.slave  rf_bus
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          r_last_grant, w_last_grant_nxt;
  logic          r_we, w_we_nxt;
  logic [AW-1:0] r_waddr, w_waddr_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic          w_ready0, w_ready1;
  logic          w_xfer, w_winner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_we         <= w_we_nxt;
      r_waddr      <= w_waddr_nxt;
      r_wdata      <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_we_nxt         = 1'b0;
    w_waddr_nxt      = r_waddr;
    w_wdata_nxt      = r_wdata;
    w_ready0         = 1'b0;
    w_ready1         = 1'b0;
    w_xfer           = 1'b0;
    w_winner         = 1'b0;
    case (r_state)
      ARB: begin
        if (rf_bus.clr_start) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          // On a tie, the requester that was not granted last wins.
          if (rf_bus.req0_valid && rf_bus.req1_valid) begin
            w_ready0 = r_last_grant;
            w_ready1 = ~r_last_grant;
          end else begin
            w_ready0 = rf_bus.req0_valid;
            w_ready1 = rf_bus.req1_valid;
          end
          w_xfer   = w_ready0 | w_ready1;
          w_winner = w_ready1;
          if (w_xfer) begin
            w_last_grant_nxt = w_winner;
            w_waddr_nxt      = w_winner ? rf_bus.req1_addr : rf_bus.req0_addr;
            w_wdata_nxt      = w_winner ? rf_bus.req1_data : rf_bus.req0_data;
`ifdef RF_ZERO_GUARD_EN
            w_we_nxt         = (w_waddr_nxt != '0);
`else
            w_we_nxt         = 1'b1;
`endif
          end
        end
      end
      CLEAR: begin
        w_we_nxt    = 1'b1;
        w_waddr_nxt = r_cnt;
        w_wdata_nxt = '0;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  assign rf_bus.req0_ready = w_ready0;
  assign rf_bus.req1_ready = w_ready1;
  assign rf_bus.busy       = (r_state == CLEAR);
  assign rf_bus.last_grant = r_last_grant;
  assign rf_bus.rf_we      = r_we;
  assign rf_bus.rf_waddr   = r_waddr;
  assign rf_bus.rf_wdata   = r_wdata;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb: a per-cycle model check plus literal expectations
// for the grant sequence, the clear sweep, reset abort and the register-0 guard.
module tb_regfile_wr_arb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 32;
`ifdef RF_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wr_arb_if #(.AW(AW), .DW(DW)) bus ();
  regfile_wr_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rf_bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file attached to the write port, with a preload path for the tests.
  logic [DW-1:0] rf_mem [DEPTH];
  logic          preload_en = 1'b0;
  logic [DW-1:0] preload_base = '0;
  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < DEPTH; i++) rf_mem[i] <= preload_base + DW'(i);
    end else if (bus.rf_we) begin
      rf_mem[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  // Model: sweep cycles remaining, last winner, expected registered outputs.
  int            m_left;
  int            m_last;
  logic          e_we;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_we", bus.rf_we, 0);
      check("rst_waddr", bus.rf_waddr, 0);
      check("rst_wdata", bus.rf_wdata, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_last", bus.last_grant, 1);
      m_left = 0; m_last = 1; e_we = 0; e_waddr = '0; e_wdata = '0;
    end else begin
      int win;
      win = -1;
      if (m_left == 0 && !bus.clr_start) begin
        if (bus.req0_valid && bus.req1_valid) win = (m_last == 0) ? 1 : 0;
        else if (bus.req0_valid) win = 0;
        else if (bus.req1_valid) win = 1;
      end
      check("m_ready0", bus.req0_ready, (win == 0));
      check("m_ready1", bus.req1_ready, (win == 1));
      check("m_busy", bus.busy, (m_left > 0));
      check("m_last", bus.last_grant, m_last[0]);
      check("m_we", bus.rf_we, e_we);
      check("m_waddr", bus.rf_waddr, e_waddr);
      check("m_wdata", bus.rf_wdata, e_wdata);
      if (m_left > 0) begin
        e_we = 1; e_waddr = AW'(DEPTH - m_left); e_wdata = '0;
        m_left--;
      end else if (bus.clr_start) begin
        m_left = DEPTH; e_we = 0;
      end else if (win >= 0) begin
        e_waddr = (win == 1) ? bus.req1_addr : bus.req0_addr;
        e_wdata = (win == 1) ? bus.req1_data : bus.req0_data;
        e_we    = !(GUARD && e_waddr == 0);
        m_last  = win;
      end else begin
        e_we = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int n, bad;
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.clr_start = 0;
    do_reset();

    // Single request, one-cycle latency.
    bus.req0_valid = 1; bus.req0_addr = 5'd3; bus.req0_data = 32'hAA;
    #1 check("t1_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    check("t1_we", bus.rf_we, 1);
    check("t1_waddr", bus.rf_waddr, 3);
    check("t1_wdata", bus.rf_wdata, 32'hAA);
    tick();
    check("t1_mem3", rf_mem[3], 32'hAA);

    // Contention from reset: grants 0,1,0,1.
    do_reset();
    bus.req0_valid = 1; bus.req0_addr = 5'd1; bus.req0_data = 32'h11;
    bus.req1_valid = 1; bus.req1_addr = 5'd2; bus.req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_ready0", bus.req0_ready, (i % 2 == 0));
      check("t2_ready1", bus.req1_ready, (i % 2 == 1));
      @(posedge clk); #1;
      check("t2_waddr", bus.rf_waddr, (i % 2 == 0) ? 1 : 2);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    check("t2_last", bus.last_grant, 1);

    // Full clear with preload, a concurrent req1 and a stray clr_start mid-sweep.
    preload_base = 32'hA5A5_0001; preload_en = 1; tick(); preload_en = 0;
    bus.clr_start = 1;
    bus.req1_valid = 1; bus.req1_addr = 5'd7; bus.req1_data = 32'h77;
    #1 check("t3_ready1_clr", bus.req1_ready, 0);
    tick();
    bus.clr_start = 0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      bus.clr_start = (n == 5);
      tick();
    end
    bus.clr_start = 0;
    check("t3_busy_cycles", n, 32);
    #1;
    check("t3_ready1_after", bus.req1_ready, 1);
    check("t3_last_sweep_addr", bus.rf_waddr, 31);
    tick();
    bus.req1_valid = 0;
    check("t3_req1_we", bus.rf_we, 1);
    check("t3_req1_waddr", bus.rf_waddr, 7);
    check("t3_req1_wdata", bus.rf_wdata, 32'h77);
    tick();
    check("t3_busy_after", bus.busy, 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (i != 7 && rf_mem[i] != 0) bad++;
    check("t3_nonzero_regs", bad, 0);
    check("t3_mem7", rf_mem[7], 32'h77);

    // Reset while the sweep is at address 10.
    preload_base = 32'h1234_0001; preload_en = 1; tick(); preload_en = 0;
    bus.clr_start = 1; tick(); bus.clr_start = 0;
    n = 0;
    while (!(bus.rf_we && bus.rf_waddr == 10) && n < 60) begin
      n++; tick();
    end
    check("t4_reached_addr10", (bus.rf_we && bus.rf_waddr == 10), 1);
    rst = 1;
    #1 check("t4_we_drop", bus.rf_we, 0);
    tick();
    rst = 0;
    tick(); tick();
    check("t4_busy", bus.busy, 0);
    check("t4_we_idle", bus.rf_we, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) if (rf_mem[i] != 0) bad++;
    check("t4_cleared_0_9", bad, 0);
    bad = 0;
    for (int i = 10; i < DEPTH; i++) if (rf_mem[i] != 32'h1234_0001 + i) bad++;
    check("t4_kept_10_31", bad, 0);

    // Requester write to register 0.
    bus.req0_valid = 1; bus.req0_addr = 5'd0; bus.req0_data = 32'd5;
    #1 check("t5_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    check("t5_we", bus.rf_we, GUARD ? 0 : 1);
    check("t5_last", bus.last_grant, 0);
    tick();
    check("t5_mem0", rf_mem[0], GUARD ? 32'd0 : 32'd5);

    // Back-to-back single-requester writes, top address.
    bus.req1_valid = 1; bus.req1_addr = 5'd31; bus.req1_data = 32'hDEAD_BEEF;
    tick();
    bus.req1_addr = 5'd30; bus.req1_data = 32'h0BAD_F00D;
    tick();
    bus.req1_valid = 0;
    check("t6_waddr", bus.rf_waddr, 30);
    tick();
    check("t6_mem31", rf_mem[31], 32'hDEAD_BEEF);
    check("t6_mem30", rf_mem[30], 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
